risc_sequencer: RTL and testbench
=================================

Name: risc_sequencer

Overview:
- Instruction sequencer for the VeriRISC CPU. Steps the datapath through the 8-phase fetch/execute cycle and decodes the current `opcode_t` plus the ALU `zero` flag into memory, register, PC and bus strobes.
- Adds run/step/halt control for bring-up and debug.
- Adds a retired-instruction counter.
- Sits between the instruction register/ALU and the memory, accumulator, PC and IR load enables.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  3 (opcode_t)  current IR opcode. Encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  input  1  ALU accumulator-zero flag.
- run  input  1  1 = free-run instructions back to back.
- step  input  1  single-cycle pulse; runs exactly one instruction when run=0.
- resume  input  1  single-cycle pulse; leaves HALTED.
- sel  output  1  address mux select (1 = PC, 0 = IR operand).
- mem_rd  output  1  memory read strobe.
- load_ir  output  1  IR load enable.
- inc_pc  output  1  PC increment.
- load_pc  output  1  PC load from operand.
- load_ac  output  1  accumulator load.
- mem_wr  output  1  memory write strobe.
- data_e  output  1  accumulator-to-bus drive enable.
- halt  output  1  high in the HLT-detect phase and throughout HALTED.
- phase  output  3  current phase index (0..7); 0 while WAIT/HALTED.
- busy  output  1  high in phases 0..7 of an active instruction.
- instr_done  output  1  one-cycle pulse in the last cycle of each retired instruction.
- instr_cnt  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.

Behaviour:
- States: WAIT, P0 INST_ADDR, P1 INST_FETCH, P2 INST_LOAD, P3 IDLE, P4 OP_ADDR, P5 OP_FETCH, P6 ALU_OP, P7 STORE, HALTED.
- Reset (sync, overrides all): state=WAIT, instr_cnt=0. All strobes, halt, busy and instr_done are 0; phase=0.
- Reset mid-instruction or while HALTED aborts to WAIT next edge; no strobe is asserted in the reset cycle.
- WAIT → P0 when run=1, or when step=1. Otherwise stay in WAIT. A step with run=1 has no extra effect.
- P0 → P1 → … → P7 unconditionally, one clock each. Inputs run and step are ignored mid-instruction.
- After P7:
  - run=1 → P0 directly (back-to-back, no bubble).
  - run=0 → WAIT.
- At P4 with opcode==HLT → HALTED instead of P5. The instruction counts as retired: instr_done pulses in P4.
- HALTED → WAIT on resume=1. Otherwise HALTED holds; run and step are ignored.
- Strobes are combinational from the registered state and opcode (zero-latency decode). ALUOP = ADD|AND|XOR|LDA.
  - WAIT/HALTED: all strobes 0, except halt=1 in HALTED.
  - P0: sel.
  - P1: sel, mem_rd.
  - P2: sel, mem_rd, load_ir.
  - P3: sel, mem_rd, load_ir.
  - P4: inc_pc; halt=(opcode==HLT).
  - P5: mem_rd=ALUOP.
  - P6: mem_rd=ALUOP; inc_pc=(SKZ & zero); load_pc=JMP; data_e=STO.
  - P7: mem_rd=ALUOP; load_ac=ALUOP; inc_pc=JMP; load_pc=JMP; mem_wr=STO; data_e=STO.
- opcode is sampled combinationally each phase. The datapath holds the IR stable from P3 onward.
- instr_done pulses in P7, or in P4 for HLT. instr_cnt increments on the same clock edge and wraps from all-ones to 0.
- mem_wr and load_ac are never high outside P7. mem_rd and mem_wr are never high together.

Test Plan:
- Reset mid-instruction: rst high during P5 → next cycle state WAIT, phase=0, all strobes 0, instr_cnt=0.
- Free-run ADD, then LDA, with run=1:
  - 16 consecutive cycles P0..P7 twice.
  - mem_rd high in P1–P3 and P5–P7.
  - load_ac high exactly in cycles 7 and 15.
  - instr_cnt=2 after cycle 15.
- Back-to-back SKZ:
  - zero=1 → inc_pc high in P4 and P6.
  - zero=0 → inc_pc high only in P4.
  - No load_pc or mem_wr in either case.
- Single step with run=0:
  - step pulse → P0..P7 → WAIT; exactly one instr_done; instr_cnt=1.
  - A second step pulse during P3 is ignored.
- Store and jump:
  - STO → data_e high in P6–P7, mem_wr high in P7 only.
  - JMP → load_pc high in P6–P7, inc_pc high in P4 and P7.
- Halt and counter wrap:
  - HLT → halt=1 in P4, then HALTED with halt held 1 for ≥10 cycles, run ignored.
  - resume → WAIT.
  - With CNT_W=2, four retired instructions wrap instr_cnt 3→0.

Source files
------------

// File: rtl/risc_sequencer.sv
// VeriRISC instruction sequencer: walks the eight fetch/execute phases, decodes
// opcode and zero flag into datapath strobes, adds run/step/halt control and a retired count.
module risc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             run,
  input  logic             step,
  input  logic             resume,
  output logic             sel,
  output logic             mem_rd,
  output logic             load_ir,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_ac,
  output logic             mem_wr,
  output logic             data_e,
  output logic             halt,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3,
    OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7
  } opcode_t;

  // Phases share their index with the low state bits so phase is a direct slice.
  typedef enum logic [3:0] {
    S_P0 = 4'd0, S_P1 = 4'd1, S_P2 = 4'd2, S_P3 = 4'd3,
    S_P4 = 4'd4, S_P5 = 4'd5, S_P6 = 4'd6, S_P7 = 4'd7,
    S_WAIT = 4'd8, S_HALTED = 4'd9
  } state_t;

  state_t  state, state_next;
  opcode_t op;
  logic    aluop;

  assign op    = opcode_t'(opcode);
  assign aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      instr_cnt <= '0;
    end else begin
      state <= state_next;
      if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_WAIT:   if (run || step) state_next = S_P0;
      S_P0:     state_next = S_P1;
      S_P1:     state_next = S_P2;
      S_P2:     state_next = S_P3;
      S_P3:     state_next = S_P4;
      S_P4:     state_next = (op == OP_HLT) ? S_HALTED : S_P5;
      S_P5:     state_next = S_P6;
      S_P6:     state_next = S_P7;
      S_P7:     state_next = run ? S_P0 : S_WAIT;
      S_HALTED: if (resume) state_next = S_WAIT;
      default:  state_next = S_WAIT;
    endcase
  end

  // Strobes decode straight from the registered state; a reset cycle forces them all low.
  always_comb begin
    sel        = 1'b0;
    mem_rd     = 1'b0;
    load_ir    = 1'b0;
    inc_pc     = 1'b0;
    load_pc    = 1'b0;
    load_ac    = 1'b0;
    mem_wr     = 1'b0;
    data_e     = 1'b0;
    halt       = 1'b0;
    instr_done = 1'b0;
    busy       = 1'b0;
    phase      = 3'd0;
    if (!rst) begin
      busy  = ~state[3];
      phase = state[3] ? 3'd0 : state[2:0];
      unique case (state)
        S_P0: sel = 1'b1;
        S_P1: begin
          sel    = 1'b1;
          mem_rd = 1'b1;
        end
        S_P2, S_P3: begin
          sel     = 1'b1;
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        S_P4: begin
          inc_pc     = 1'b1;
          halt       = (op == OP_HLT);
          instr_done = (op == OP_HLT);
        end
        S_P5: mem_rd = aluop;
        S_P6: begin
          mem_rd  = aluop;
          inc_pc  = (op == OP_SKZ) && zero;
          load_pc = (op == OP_JMP);
          data_e  = (op == OP_STO);
        end
        S_P7: begin
          mem_rd     = aluop;
          load_ac    = aluop;
          inc_pc     = (op == OP_JMP);
          load_pc    = (op == OP_JMP);
          mem_wr     = (op == OP_STO);
          data_e     = (op == OP_STO);
          instr_done = 1'b1;
        end
        S_HALTED: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// Bench for risc_sequencer: directed scenarios plus random traffic, checked per cycle
// against a phase-table model; a second instance with a 2-bit counter covers wrap.
module tb_risc_sequencer;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDI = 3'd3,
                         XORI = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1, run = 1'b0, step = 1'b0, resume = 1'b0, zero = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic        sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e;
  logic        halt, busy, instr_done;
  logic [2:0]  phase;
  logic [15:0] instr_cnt;
  logic        w_sel, w_mem_rd, w_load_ir, w_inc_pc, w_load_pc, w_load_ac, w_mem_wr, w_data_e;
  logic        w_halt, w_busy, w_instr_done;
  logic [2:0]  w_phase;
  logic [1:0]  w_instr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // model: -1 = WAIT, 0..7 = phase, 8 = HALTED
  int          m_ph  = -1;
  logic [15:0] m_cnt = '0;
  int          load_ac_hits, done_hits, halt_hits;

  always #5 clk = ~clk;

  risc_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .run(run), .step(step),
    .resume(resume), .sel(sel), .mem_rd(mem_rd), .load_ir(load_ir), .inc_pc(inc_pc),
    .load_pc(load_pc), .load_ac(load_ac), .mem_wr(mem_wr), .data_e(data_e), .halt(halt),
    .phase(phase), .busy(busy), .instr_done(instr_done), .instr_cnt(instr_cnt)
  );

  risc_sequencer #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .run(run), .step(step),
    .resume(resume), .sel(w_sel), .mem_rd(w_mem_rd), .load_ir(w_load_ir),
    .inc_pc(w_inc_pc), .load_pc(w_load_pc), .load_ac(w_load_ac), .mem_wr(w_mem_wr),
    .data_e(w_data_e), .halt(w_halt), .phase(w_phase), .busy(w_busy),
    .instr_done(w_instr_done), .instr_cnt(w_instr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {sel,mem_rd,load_ir,inc_pc,load_pc,load_ac,mem_wr,data_e,halt,busy,instr_done,phase[2:0]}
  function automatic logic [13:0] exp_out(input int ph, input logic [2:0] op,
                                          input logic z, input logic r);
    logic alu;
    logic s, rd, ir, ip, lp, la, wr, de, h, d;
    alu = (op == ADD) || (op == ANDI) || (op == XORI) || (op == LDA);
    {s, rd, ir, ip, lp, la, wr, de, h, d} = '0;
    if (r) return 14'd0;
    case (ph)
      0: s = 1'b1;
      1: {s, rd} = 2'b11;
      2, 3: {s, rd, ir} = 3'b111;
      4: begin ip = 1'b1; h = (op == HLT); d = (op == HLT); end
      5: rd = alu;
      6: begin rd = alu; ip = (op == SKZ) & z; lp = (op == JMP); de = (op == STO); end
      7: begin
        rd = alu; la = alu; ip = (op == JMP); lp = (op == JMP);
        wr = (op == STO); de = (op == STO); d = 1'b1;
      end
      8: h = 1'b1;
      default: ;
    endcase
    return {s, rd, ir, ip, lp, la, wr, de, h, (ph >= 0 && ph <= 7), d,
            (ph >= 0 && ph <= 7) ? 3'(ph) : 3'd0};
  endfunction

  // One clock: drive inputs at the falling edge, push the expectation, compare, advance model.
  task automatic drive(input logic r, input logic rn, input logic st, input logic rs,
                       input logic [2:0] op, input logic z);
    logic [31:0] e;
    logic [13:0] o;
    @(negedge clk);
    rst = r; run = rn; step = st; resume = rs; opcode = op; zero = z;
    #1;
    o = exp_out(m_ph, op, z, r);
    exp_q.push_back({m_cnt, m_cnt[1:0], o});
    e = exp_q.pop_front();
    check("strobes", {18'd0, sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e,
                      halt, busy, instr_done, phase}, {18'd0, e[13:0]});
    check("cnt", {16'd0, instr_cnt}, {16'd0, e[31:16]});
    check("cnt_w2", {30'd0, w_instr_cnt}, {30'd0, e[15:14]});
    if (load_ac) load_ac_hits++;
    if (instr_done) done_hits++;
    if (halt) halt_hits++;
    if (r) begin
      m_ph = -1; m_cnt = '0;
    end else begin
      if (o[3]) m_cnt = m_cnt + 16'd1;
      case (m_ph)
        -1: if (rn || st) m_ph = 0;
        4: m_ph = (op == HLT) ? 8 : 5;
        7: m_ph = rn ? 0 : -1;
        8: if (rs) m_ph = -1;
        default: m_ph = m_ph + 1;
      endcase
    end
  endtask

  task automatic instr(input logic [2:0] op, input logic z, input logic rn_last);
    for (int i = 0; i < 8; i++) drive(1'b0, (i == 7) ? rn_last : 1'b1, 1'b0, 1'b0, op, z);
  endtask

  task automatic after_edge_check(input string tag, input logic [31:0] obs_sel,
                                  input logic [31:0] exp);
    check(tag, obs_sel, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, ADD, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, ADD, 1'b0);

    // free-run ADD then LDA from WAIT
    drive(1'b0, 1'b1, 1'b0, 1'b0, ADD, 1'b0);
    load_ac_hits = 0;
    instr(ADD, 1'b0, 1'b1);
    instr(LDA, 1'b0, 1'b1);
    check("load_ac_pulses", 32'(load_ac_hits), 32'd2);
    @(posedge clk); #1;
    check("cnt_after_two", {16'd0, instr_cnt}, 32'd2);

    instr(SKZ, 1'b1, 1'b1);
    instr(SKZ, 1'b0, 1'b1);
    instr(STO, 1'b0, 1'b1);
    instr(JMP, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, ADD, 1'b0);

    // single step, second step during P3 ignored
    done_hits = 0;
    for (int c = 0; c < 11; c++)
      drive(1'b0, 1'b0, (c == 0 || c == 4), 1'b0, XORI, 1'b1);
    check("step_done_once", 32'(done_hits), 32'd1);

    // reset during P5
    for (int c = 0; c < 9; c++)
      drive(c == 6, c < 6, 1'b0, 1'b0, ANDI, 1'b0);
    check("cnt_after_rst", {16'd0, instr_cnt}, 32'd0);

    // halt: run held high while halted
    halt_hits = 0;
    for (int c = 0; c < 18; c++)
      drive(1'b0, 1'b1, c[0], 1'b0, HLT, 1'b0);
    check("halt_cycles", 32'(halt_hits), 32'd13);
    drive(1'b0, 1'b0, 1'b0, 1'b1, HLT, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, HLT, 1'b0);
    check("halt_released", {31'd0, halt}, 32'd0);

    // counter wrap on the 2-bit instance
    drive(1'b1, 1'b0, 1'b0, 1'b0, ADD, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, ADD, 1'b0);
    for (int k = 0; k < 4; k++) instr(ADD, 1'b0, k != 3);
    @(posedge clk); #1;
    check("wrap_w2", {30'd0, w_instr_cnt}, 32'd0);
    check("no_wrap_w16", {16'd0, instr_cnt}, 32'd4);

    // random traffic
    for (int c = 0; c < 400; c++)
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
